ysyx_25040129_lsu_ctrl: RTL and testbench

//  Memory stage directly downstream of the execute stage. Takes the ALU result/address, store data and

---
 rtl/ysyx_25040129_lsu_pkg.sv | 48 ++++
 rtl/ysyx_25040129_lsu_align.sv | 39 +++
 rtl/ysyx_25040129_lsu_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_25040129_lsu_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the LSU: load/store opcodes, register index width,
// FSM state encodings and small access-size helpers.
package ysyx_25040129_lsu_pkg;

  localparam int REGS_DIG = 5;

  localparam logic [2:0] NO_MEM_READ = 3'b000;
  localparam logic [2:0] LB          = 3'b001;
  localparam logic [2:0] LH          = 3'b010;
  localparam logic [2:0] LW          = 3'b011;
  localparam logic [2:0] LBU         = 3'b100;
  localparam logic [2:0] LHU         = 3'b101;

  localparam logic [1:0] NO_MEM_WRITE = 2'b00;
  localparam logic [1:0] SB           = 2'b01;
  localparam logic [1:0] SH           = 2'b10;
  localparam logic [1:0] SW           = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR   = 3'd3,
    S_WR_B = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  function automatic logic [2:0] rd_size(input logic [2:0] op);
    case (op)
      LH, LHU: return 3'd1;
      LW:      return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] wr_size(input logic [1:0] op);
    case (op)
      SH:      return 3'd1;
      SW:      return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return ((size == 3'd1) && addr_lo[0]) || ((size == 3'd2) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational byte-lane handling: store data/strobe placement and load
// data extraction with sign or zero extension.
module ysyx_25040129_lsu_align
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic [2:0]  rd_op,
  input  logic [1:0]  wr_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [4:0]  lane_shift;
  logic [31:0] rd_shifted;

  assign lane_shift = {addr_lo, 3'b000};

  always_comb begin
    wdata      = store_data << lane_shift;
    rd_shifted = rdata >> lane_shift;
    case (wr_op)
      SB:      wstrb = 4'b0001 << addr_lo;
      SH:      wstrb = 4'b0011 << addr_lo;
      SW:      wstrb = 4'b1111 << addr_lo;
      default: wstrb = 4'b0000;
    endcase
    case (rd_op)
      LB:      load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      LH:      load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      LBU:     load_data = {24'd0, rd_shifted[7:0]};
      LHU:     load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_lsu_ctrl.sv
// Memory stage: one AXI4-Lite style access at a time between EXU and WBU,
// with misalignment, bus-error and timeout faults folded into the result.
//
// state  | meaning
// IDLE   | no request held, ready for EXU
// RD_A   | read address presented
// RD_D   | waiting for read data
// WR     | write address and data presented, each retired independently
// WR_B   | waiting for write response
// DONE   | result valid to WBU, held until accepted
module ysyx_25040129_lsu_ctrl
  import ysyx_25040129_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                is_req_valid_from_exu,
  output logic                is_req_ready_to_exu,
  input  logic [31:0]         addr_in_lsu,
  input  logic [31:0]         lsu_write_data_in_lsu,
  input  logic [2:0]          lsu_read_in_lsu,
  input  logic [1:0]          lsu_write_in_lsu,
  input  logic [REGS_DIG-1:0] rd_in_lsu,
  input  logic                reg_write_in_lsu,
  output logic [31:0]         araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [31:0]         awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                is_req_valid_to_wbu,
  input  logic                is_req_ready_from_wbu,
  output logic [31:0]         result_out_lsu,
  output logic [REGS_DIG-1:0] rd_out_lsu,
  output logic                reg_write_out_lsu,
  output logic                lsu_fault_out_lsu,
  output logic                is_data_forward_valid_from_lsu
);

  localparam logic [31:0] TMO_LOAD = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  lsu_state_e          state_q, state_d;
  logic [31:0]         addr_q, addr_d, data_q, data_d, result_q, result_d, tmo_q, tmo_d;
  logic [2:0]          rd_op_q, rd_op_d;
  logic [1:0]          wr_op_q, wr_op_d;
  logic [REGS_DIG-1:0] rd_q, rd_d;
  logic                reg_write_q, reg_write_d, fault_q, fault_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                accept, tmo_hit, req_load, req_store, req_misalign;
  logic [31:0]         load_data;

  ysyx_25040129_lsu_align u_align (
    .rd_op      (rd_op_q),
    .wr_op      (wr_op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (data_q),
    .rdata      (rdata),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data)
  );

  assign is_req_ready_to_exu = (state_q == S_IDLE) | ((state_q == S_DONE) & is_req_ready_from_wbu);
  assign accept              = is_req_valid_from_exu & is_req_ready_to_exu;

  // A load opcode wins if EXU ever presents both.
  assign req_load     = (lsu_read_in_lsu != NO_MEM_READ);
  assign req_store    = !req_load && (lsu_write_in_lsu != NO_MEM_WRITE);
  assign req_misalign = misaligned(req_load ? rd_size(lsu_read_in_lsu) : wr_size(lsu_write_in_lsu),
                                   addr_in_lsu[1:0]);
  assign tmo_hit      = (TIMEOUT_CYC != 0) && (tmo_q == 32'd0);

  assign araddr  = addr_q;
  assign arsize  = rd_size(rd_op_q);
  assign arvalid = (state_q == S_RD_A);
  assign rready  = (state_q == S_RD_D);
  assign awaddr  = addr_q;
  assign awsize  = wr_size(wr_op_q);
  assign awvalid = (state_q == S_WR) && !aw_done_q;
  assign wvalid  = (state_q == S_WR) && !w_done_q;
  assign bready  = (state_q == S_WR_B);

  assign is_req_valid_to_wbu            = (state_q == S_DONE);
  assign is_data_forward_valid_from_lsu = (state_q == S_DONE);
  assign result_out_lsu                 = result_q;
  assign rd_out_lsu                     = rd_q;
  assign reg_write_out_lsu              = reg_write_q;
  assign lsu_fault_out_lsu              = fault_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_op_d     = rd_op_q;
    wr_op_d     = wr_op_q;
    rd_d        = rd_q;
    result_d    = result_q;
    reg_write_d = reg_write_q;
    fault_d     = fault_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    case (state_q)
      S_RD_A: begin
        if (arready) begin
          state_d = S_RD_D;
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          fault_d     = 1'b1;
          reg_write_d = 1'b0;
        end
      end
      S_RD_D: begin
        if (rvalid) begin
          state_d  = S_DONE;
          result_d = load_data;
          if (rresp != 2'b00) begin
            fault_d     = 1'b1;
            reg_write_d = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          fault_d     = 1'b1;
          reg_write_d = 1'b0;
        end
      end
      S_WR: begin
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) begin
          state_d = S_WR_B;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      end
      S_WR_B: begin
        if (bvalid) begin
          state_d = S_DONE;
          fault_d = (bresp != 2'b00);
        end else if (tmo_hit) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      end
      S_DONE: begin
        if (is_req_ready_from_wbu) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance in IDLE or DONE overrides whatever the state above decided.
    if (accept) begin
      addr_d      = addr_in_lsu;
      data_d      = lsu_write_data_in_lsu;
      rd_op_d     = lsu_read_in_lsu;
      wr_op_d     = req_load ? NO_MEM_WRITE : lsu_write_in_lsu;
      rd_d        = rd_in_lsu;
      result_d    = addr_in_lsu;
      fault_d     = 1'b0;
      aw_done_d   = 1'b0;
      w_done_d    = 1'b0;
      reg_write_d = reg_write_in_lsu;
      if (req_misalign) begin
        state_d     = S_DONE;
        fault_d     = 1'b1;
        reg_write_d = 1'b0;
      end else if (req_load) begin
        state_d = S_RD_A;
      end else if (req_store) begin
        state_d     = S_WR;
        reg_write_d = 1'b0;
      end else begin
        state_d = S_DONE;
      end
    end

    tmo_d = (state_d != state_q) ? TMO_LOAD : ((tmo_q != 32'd0) ? tmo_q - 32'd1 : tmo_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      rd_op_q     <= NO_MEM_READ;
      wr_op_q     <= NO_MEM_WRITE;
      rd_q        <= '0;
      result_q    <= 32'd0;
      reg_write_q <= 1'b0;
      fault_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tmo_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_op_q     <= rd_op_d;
      wr_op_q     <= wr_op_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      reg_write_q <= reg_write_d;
      fault_q     <= fault_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_lsu_ctrl.sv
// Bench for the LSU: scoreboarded WBU results against a configurable
// AXI-Lite slave model, plus direct checks of bus-side behaviour.
module tb_ysyx_25040129_lsu_ctrl;
  import ysyx_25040129_lsu_pkg::*;

  typedef struct {
    logic [31:0]         result;
    logic                chk_res;
    logic [REGS_DIG-1:0] rd;
    logic                rw;
    logic                fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic is_req_valid_from_exu, is_req_ready_to_exu;
  logic [31:0] addr_in_lsu, lsu_write_data_in_lsu;
  logic [2:0] lsu_read_in_lsu;
  logic [1:0] lsu_write_in_lsu;
  logic [REGS_DIG-1:0] rd_in_lsu;
  logic reg_write_in_lsu;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;
  logic is_req_valid_to_wbu, is_req_ready_from_wbu;
  logic [31:0] result_out_lsu;
  logic [REGS_DIG-1:0] rd_out_lsu;
  logic reg_write_out_lsu, lsu_fault_out_lsu, is_data_forward_valid_from_lsu;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  exp_t sb_e;

  // slave model configuration and observation
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit ar_never = 0;
  logic [31:0] rdata_v = 32'd0;
  logic [1:0] rresp_v = 2'b00, bresp_v = 2'b00;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  int ar_xfers = 0, aw_xfers = 0, w_xfers = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [2:0] cap_arsize = 0, cap_awsize = 0;
  logic [3:0] cap_wstrb = 0;
  bit ar_hold = 0, w_hold = 0;
  logic [31:0] ar_hold_addr = 0, w_hold_data = 0;

  ysyx_25040129_lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .is_req_valid_from_exu(is_req_valid_from_exu), .is_req_ready_to_exu(is_req_ready_to_exu),
    .addr_in_lsu(addr_in_lsu), .lsu_write_data_in_lsu(lsu_write_data_in_lsu),
    .lsu_read_in_lsu(lsu_read_in_lsu), .lsu_write_in_lsu(lsu_write_in_lsu),
    .rd_in_lsu(rd_in_lsu), .reg_write_in_lsu(reg_write_in_lsu),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .is_req_valid_to_wbu(is_req_valid_to_wbu), .is_req_ready_from_wbu(is_req_ready_from_wbu),
    .result_out_lsu(result_out_lsu), .rd_out_lsu(rd_out_lsu),
    .reg_write_out_lsu(reg_write_out_lsu), .lsu_fault_out_lsu(lsu_fault_out_lsu),
    .is_data_forward_valid_from_lsu(is_data_forward_valid_from_lsu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic cr,
                              input logic [REGS_DIG-1:0] rd, input logic rw, input logic f);
    exp_t e;
    e.result = r; e.chk_res = cr; e.rd = rd; e.rw = rw; e.fault = f;
    return e;
  endfunction

  // slave: readies after a configurable number of waiting cycles
  assign arready = arvalid && !ar_never && (ar_wait >= ar_dly);
  assign rvalid  = r_pend && (r_wait >= r_dly);
  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign bvalid  = b_pend && (b_wait >= b_dly);
  assign rdata   = rdata_v;
  assign rresp   = rresp_v;
  assign bresp   = bresp_v;

  always @(posedge clk) begin
    if (reset) begin
      ar_wait <= 0; r_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      r_pend <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0;
    end else begin
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (arvalid && arready) begin
        ar_xfers <= ar_xfers + 1; cap_araddr <= araddr; cap_arsize <= arsize;
        r_pend <= 1; r_wait <= 0;
      end else if (r_pend && !rvalid) r_wait <= r_wait + 1;
      if (rvalid && rready) r_pend <= 0;
      if (awvalid && awready) begin
        aw_xfers <= aw_xfers + 1; cap_awaddr <= awaddr; cap_awsize <= awsize; aw_got <= 1;
      end
      if (wvalid && wready) begin
        w_xfers <= w_xfers + 1; cap_wdata <= wdata; cap_wstrb <= wstrb; w_got <= 1;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !b_pend) begin
        b_pend <= 1; b_wait <= 0; aw_got <= 0; w_got <= 0;
      end else if (b_pend && !bvalid) b_wait <= b_wait + 1;
      if (bvalid && bready) b_pend <= 0;
    end
  end

  // WBU-side scoreboard and bus stability monitor
  always @(negedge clk) begin
    if (reset) begin
      ar_hold <= 0; w_hold <= 0;
    end else begin
      if (is_req_valid_to_wbu && is_req_ready_from_wbu) begin
        if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
        else begin
          sb_e = sb.pop_front();
          if (sb_e.chk_res) chk("result", result_out_lsu, sb_e.result);
          chk("rd_out", 32'(rd_out_lsu), 32'(sb_e.rd));
          chk("reg_write_out", 32'(reg_write_out_lsu), 32'(sb_e.rw));
          chk("fault", 32'(lsu_fault_out_lsu), 32'(sb_e.fault));
          chk("fwd_valid", 32'(is_data_forward_valid_from_lsu), 32'd1);
        end
      end
      if (ar_hold && !is_req_valid_to_wbu) begin
        chk("ar_hold_valid", 32'(arvalid), 32'd1);
        chk("ar_hold_addr", araddr, ar_hold_addr);
      end
      if (w_hold && !is_req_valid_to_wbu) begin
        chk("w_hold_valid", 32'(wvalid), 32'd1);
        chk("w_hold_data", wdata, w_hold_data);
      end
      ar_hold <= arvalid && !arready; ar_hold_addr <= araddr;
      w_hold  <= wvalid && !wready;   w_hold_data  <= wdata;
    end
  end

  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] rop,
                          input logic [1:0] wop, input logic [REGS_DIG-1:0] rd, input logic rw,
                          input exp_t e);
    bit done = 0;
    sb.push_back(e);
    addr_in_lsu = a; lsu_write_data_in_lsu = d; lsu_read_in_lsu = rop;
    lsu_write_in_lsu = wop; rd_in_lsu = rd; reg_write_in_lsu = rw;
    is_req_valid_from_exu = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (is_req_ready_to_exu) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    is_req_valid_from_exu = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  int ar0, aw0, w0, n_ar;

  initial begin
    reset = 1'b1;
    is_req_valid_from_exu = 0; addr_in_lsu = 0; lsu_write_data_in_lsu = 0;
    lsu_read_in_lsu = NO_MEM_READ; lsu_write_in_lsu = NO_MEM_WRITE; rd_in_lsu = 0;
    reg_write_in_lsu = 0; is_req_ready_from_wbu = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_wbu", 32'(is_req_valid_to_wbu), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_fault", 32'(lsu_fault_out_lsu), 0);
    chk("rst_reg_write", 32'(reg_write_out_lsu), 0);
    chk("rst_result", result_out_lsu, 0);
    chk("rst_rd", 32'(rd_out_lsu), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready_exu", 32'(is_req_ready_to_exu), 1);

    // pass-through ALU result, one-cycle latency, no bus traffic
    ar0 = ar_xfers; aw0 = aw_xfers; w0 = w_xfers;
    send_req(32'h1234, 0, NO_MEM_READ, NO_MEM_WRITE, 5'd5, 1'b1, mk(32'h1234, 1, 5'd5, 1, 0));
    chk("alu_latency", 32'(is_req_valid_to_wbu), 1);
    wait_drain();
    chk("alu_no_ar", ar_xfers - ar0, 0);
    chk("alu_no_aw", aw_xfers - aw0, 0);
    chk("alu_no_w", w_xfers - w0, 0);

    // loads
    rdata_v = 32'h80FF_FFFF;
    send_req(32'h8000_0003, 0, LB, NO_MEM_WRITE, 5'd1, 1'b1, mk(32'hFFFF_FF80, 1, 5'd1, 1, 0));
    wait_drain();
    chk("lb_araddr", cap_araddr, 32'h8000_0003);
    chk("lb_arsize", 32'(cap_arsize), 0);
    send_req(32'h8000_0003, 0, LBU, NO_MEM_WRITE, 5'd2, 1'b1, mk(32'h0000_0080, 1, 5'd2, 1, 0));
    wait_drain();
    rdata_v = 32'h8001_0000;
    send_req(32'h8000_0002, 0, LH, NO_MEM_WRITE, 5'd3, 1'b1, mk(32'hFFFF_8001, 1, 5'd3, 1, 0));
    wait_drain();
    chk("lh_arsize", 32'(cap_arsize), 1);
    send_req(32'h8000_0002, 0, LHU, NO_MEM_WRITE, 5'd4, 1'b1, mk(32'h0000_8001, 1, 5'd4, 1, 0));
    wait_drain();
    rdata_v = 32'hDEAD_BEEF; ar_dly = 1; r_dly = 2;
    send_req(32'h8000_0004, 0, LW, NO_MEM_WRITE, 5'd6, 1'b1, mk(32'hDEAD_BEEF, 1, 5'd6, 1, 0));
    wait_drain();
    chk("lw_arsize", 32'(cap_arsize), 2);
    ar_dly = 0; r_dly = 0;

    // back-to-back acceptance from DONE
    send_req(32'h11, 0, NO_MEM_READ, NO_MEM_WRITE, 5'd2, 1'b1, mk(32'h11, 1, 5'd2, 1, 0));
    send_req(32'h22, 0, NO_MEM_READ, NO_MEM_WRITE, 5'd3, 1'b0, mk(32'h22, 1, 5'd3, 0, 0));
    wait_drain();

    // stores: AW and W accepted in different cycles
    aw0 = aw_xfers; w0 = w_xfers; aw_dly = 0; w_dly = 2;
    send_req(32'h8000_0002, 32'h0000_ABCD, NO_MEM_READ, SH, 5'd7, 1'b1, mk(0, 0, 5'd7, 0, 0));
    wait_drain();
    chk("sh_wdata", cap_wdata, 32'hABCD_0000);
    chk("sh_wstrb", 32'(cap_wstrb), 32'hC);
    chk("sh_awsize", 32'(cap_awsize), 1);
    chk("sh_awaddr", cap_awaddr, 32'h8000_0002);
    chk("sh_aw_once", aw_xfers - aw0, 1);
    chk("sh_w_once", w_xfers - w0, 1);
    w_dly = 0;
    send_req(32'h8000_0001, 32'h1234_5678, NO_MEM_READ, SB, 5'd8, 1'b0, mk(0, 0, 5'd8, 0, 0));
    wait_drain();
    chk("sb_wdata", cap_wdata, 32'h3456_7800);
    chk("sb_wstrb", 32'(cap_wstrb), 32'h2);
    aw0 = aw_xfers; w0 = w_xfers; aw_dly = 2;
    send_req(32'h8000_0010, 32'hCAFE_F00D, NO_MEM_READ, SW, 5'd9, 1'b1, mk(0, 0, 5'd9, 0, 0));
    wait_drain();
    chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("sw_wstrb", 32'(cap_wstrb), 32'hF);
    chk("sw_awsize", 32'(cap_awsize), 2);
    chk("sw_aw_once", aw_xfers - aw0, 1);
    chk("sw_w_once", w_xfers - w0, 1);
    aw_dly = 0; bresp_v = 2'b10;
    send_req(32'h8000_0013, 32'h0000_00A5, NO_MEM_READ, SB, 5'd10, 1'b1, mk(0, 0, 5'd10, 0, 1));
    wait_drain();
    chk("sb_err_wdata", cap_wdata, 32'hA500_0000);
    chk("sb_err_wstrb", 32'(cap_wstrb), 32'h8);
    bresp_v = 2'b00;

    // misalignment: no traffic, fault
    ar0 = ar_xfers; aw0 = aw_xfers;
    send_req(32'h8000_0001, 0, LW, NO_MEM_WRITE, 5'd11, 1'b1, mk(0, 0, 5'd11, 0, 1));
    chk("mis_lw_arvalid", 32'(arvalid), 0);
    wait_drain();
    send_req(32'h8000_0003, 32'h55, NO_MEM_READ, SH, 5'd12, 1'b0, mk(0, 0, 5'd12, 0, 1));
    wait_drain();
    chk("mis_no_ar", ar_xfers - ar0, 0);
    chk("mis_no_aw", aw_xfers - aw0, 0);

    // read error response
    rresp_v = 2'b10;
    send_req(32'h8000_0008, 0, LW, NO_MEM_WRITE, 5'd13, 1'b1, mk(0, 0, 5'd13, 0, 1));
    wait_drain();
    rresp_v = 2'b00;

    // address channel timeout after four cycles
    ar_never = 1;
    send_req(32'h8000_0000, 0, LW, NO_MEM_WRITE, 5'd14, 1'b1, mk(0, 0, 5'd14, 0, 1));
    n_ar = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_req_valid_to_wbu) break;
      if (arvalid) n_ar++;
    end
    chk("tmo_arvalid_cycles", n_ar, 4);
    chk("tmo_arvalid_drop", 32'(arvalid), 0);
    chk("tmo_done", 32'(is_req_valid_to_wbu), 1);
    ar_never = 0;
    wait_drain();

    // WBU back-pressure holds the result
    is_req_ready_from_wbu = 1'b0;
    send_req(32'h5A5A, 0, NO_MEM_READ, NO_MEM_WRITE, 5'd15, 1'b1, mk(32'h5A5A, 1, 5'd15, 1, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(is_req_valid_to_wbu), 1);
      chk("stall_result", result_out_lsu, 32'h5A5A);
      chk("stall_ready_exu", 32'(is_req_ready_to_exu), 0);
    end
    @(posedge clk); #1;
    is_req_ready_from_wbu = 1'b1;
    wait_drain();

    // reset while waiting for read data
    r_dly = 3; rdata_v = 32'h1111_1111;
    send_req(32'h8000_0020, 0, LW, NO_MEM_WRITE, 5'd16, 1'b1, mk(32'h1111_1111, 1, 5'd16, 1, 0));
    for (int i = 0; i < 10 && !rready; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_in_rd_d", 32'(rready), 1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_mid_arvalid", 32'(arvalid), 0);
    chk("rst_mid_rready", 32'(rready), 0);
    chk("rst_mid_awvalid", 32'(awvalid), 0);
    chk("rst_mid_wvalid", 32'(wvalid), 0);
    chk("rst_mid_bready", 32'(bready), 0);
    chk("rst_mid_valid_wbu", 32'(is_req_valid_to_wbu), 0);
    chk("rst_mid_idle", 32'(is_req_ready_to_exu), 1);
    reset = 1'b0; r_dly = 0;
    @(posedge clk); #1;
    send_req(32'h77, 0, NO_MEM_READ, NO_MEM_WRITE, 5'd17, 1'b1, mk(32'h77, 1, 5'd17, 1, 0));
    wait_drain();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
